// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target port: frame states, instruction field
// layout and the W1:W0 byte-count decode.
package spi_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INSTR = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int RW_BIT     = 15;
  localparam int W_MSB      = 14;
  localparam int W_LSB      = 13;
  localparam int INSTR_BITS = 16;
  localparam logic [3:0] INSTR_LAST_BIT = 4'(INSTR_BITS - 1);
  localparam logic [3:0] BYTE_LAST_BIT  = 4'd7;

  // Zero means streaming: transfer bytes until chip select rises.
  function automatic logic [1:0] byte_count(input logic [1:0] w);
    logic [1:0] n;
    case (w)
      2'b00:   n = 2'd1;
      2'b01:   n = 2'd2;
      2'b10:   n = 2'd3;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic is_stream(input logic [1:0] w);
    return (w == 2'b11);
  endfunction

endpackage

// File: rtl/spi_target_sync.sv
// Multi-flop synchronizer for one asynchronous pad input, with rise/fall
// detection on the synchronized level.
module spi_target_sync #(
  parameter int STAGES = 2
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;

  // Synchronizer chain plus one delayed copy of its output for edge detection
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      chain_r <= {STAGES{1'b0}};
      prev_r  <= 1'b0;
    end else begin
      chain_r[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
      prev_r <= chain_r[STAGES-1];
    end
  end

  assign level = chain_r[STAGES-1];
  assign rise  = chain_r[STAGES-1] & ~prev_r;
  assign fall  = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_target_port.sv
// SPI target port: decodes a 16-bit instruction then performs register
// writes/reads over a 3-wire interface, all in the sys_clk domain.
module spi_target_port
  import spi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 13
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              csb,
  input  logic              sdio_in,
  output logic              sdio_out,
  output logic              sdio_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic csb_hi_s, csb_rise_s, csb_fall_s;
  logic sdio_s, sdio_rise_s, sdio_fall_s;

  state_t      state_r;
  logic [3:0]  bit_cnt_r;
  logic [15:0] shift_in_r;
  logic [7:0]  shift_out_r;
  logic [1:0]  bytes_done_r;
  logic [1:0]  byte_target_r;
  logic        stream_r;
  logic [1:0]  rd_pipe_r;

  logic [15:0] instr_s;
  logic        last_byte_s;
  logic        exit_err_s;
  logic        unused_s;

  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .sys_clk (sys_clk),
    .reset   (reset),
    .din     (sclk),
    .level   (sclk_level_s),
    .rise    (sclk_rise_s),
    .fall    (sclk_fall_s)
  );

  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_csb (
    .sys_clk (sys_clk),
    .reset   (reset),
    .din     (csb),
    .level   (csb_hi_s),
    .rise    (csb_rise_s),
    .fall    (csb_fall_s)
  );

  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_sdio (
    .sys_clk (sys_clk),
    .reset   (reset),
    .din     (sdio_in),
    .level   (sdio_s),
    .rise    (sdio_rise_s),
    .fall    (sdio_fall_s)
  );

  assign unused_s = &{1'b0, sclk_level_s, csb_rise_s, sdio_rise_s, sdio_fall_s,
                      shift_in_r[15]};

  assign instr_s     = {shift_in_r[14:0], sdio_s};
  assign last_byte_s = !stream_r && ((bytes_done_r + 2'd1) == byte_target_r);

  // A csb rise is an error unless the frame ended cleanly (count met, or streaming on a byte boundary)
  always_comb begin
    exit_err_s = 1'b0;
    case (state_r)
      ST_INSTR:           exit_err_s = 1'b1;
      ST_WDATA, ST_RDATA: exit_err_s = (bit_cnt_r != 4'd0) || !stream_r;
      default:            exit_err_s = 1'b0;
    endcase
  end

  // Frame sequencer with registered strobes, address counter and read shifter
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= 4'd0;
      shift_in_r    <= 16'd0;
      shift_out_r   <= 8'd0;
      bytes_done_r  <= 2'd0;
      byte_target_r <= 2'd0;
      stream_r      <= 1'b0;
      rd_pipe_r     <= 2'b00;
      reg_addr      <= {ADDR_W{1'b0}};
      reg_wdata     <= 8'd0;
      reg_wr        <= 1'b0;
      reg_rd        <= 1'b0;
      frame_err     <= 1'b0;
      sdio_out      <= 1'b0;
      sdio_oe       <= 1'b0;
    end else begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      rd_pipe_r <= {rd_pipe_r[0], reg_rd};

      // Address steps only after the write strobe so reg_addr is stable with it
      if (reg_wr) begin
        reg_addr <= reg_addr + ADDR_ONE;
      end else begin
        reg_addr <= reg_addr;
      end

      if (rd_pipe_r[1]) begin
        shift_out_r <= reg_rdata;
      end else begin
        shift_out_r <= shift_out_r;
      end

      if ((state_r != ST_IDLE) && csb_hi_s) begin
        state_r   <= ST_IDLE;
        frame_err <= exit_err_s;
        sdio_oe   <= 1'b0;
        sdio_out  <= 1'b0;
        bit_cnt_r <= 4'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (csb_fall_s) begin
              state_r   <= ST_INSTR;
              bit_cnt_r <= 4'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end

          ST_INSTR: begin
            if (sclk_rise_s) begin
              shift_in_r <= instr_s;
              if (bit_cnt_r == INSTR_LAST_BIT) begin
                bit_cnt_r     <= 4'd0;
                bytes_done_r  <= 2'd0;
                stream_r      <= is_stream(instr_s[W_MSB:W_LSB]);
                byte_target_r <= byte_count(instr_s[W_MSB:W_LSB]);
                reg_addr      <= instr_s[ADDR_W-1:0];
                if (instr_s[RW_BIT]) begin
                  state_r <= ST_RDATA;
                  reg_rd  <= 1'b1;
                end else begin
                  state_r <= ST_WDATA;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end else begin
              state_r <= ST_INSTR;
            end
          end

          ST_WDATA: begin
            if (sclk_rise_s) begin
              shift_in_r <= instr_s;
              if (bit_cnt_r == BYTE_LAST_BIT) begin
                bit_cnt_r    <= 4'd0;
                bytes_done_r <= bytes_done_r + 2'd1;
                reg_wr       <= 1'b1;
                reg_wdata    <= instr_s[7:0];
                if (last_byte_s) begin
                  state_r <= ST_DONE;
                end else begin
                  state_r <= ST_WDATA;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end else begin
              state_r <= ST_WDATA;
            end
          end

          ST_RDATA: begin
            if (sclk_rise_s) begin
              if (bit_cnt_r == BYTE_LAST_BIT) begin
                bit_cnt_r    <= 4'd0;
                bytes_done_r <= bytes_done_r + 2'd1;
                if (last_byte_s) begin
                  state_r <= ST_DONE;
                end else begin
                  reg_addr <= reg_addr + ADDR_ONE;
                  reg_rd   <= 1'b1;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end else if (sclk_fall_s) begin
              sdio_oe     <= 1'b1;
              sdio_out    <= shift_out_r[7];
              shift_out_r <= {shift_out_r[6:0], 1'b0};
            end else begin
              state_r <= ST_RDATA;
            end
          end

          ST_DONE: begin
            // Release the pad on the first falling edge; later clocks are ignored
            if (sclk_fall_s) begin
              sdio_oe  <= 1'b0;
              sdio_out <= 1'b0;
            end else begin
              state_r <= ST_DONE;
            end
          end

          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_target_port.sv
// Directed bench for spi_target_port: acts as SPI initiator, predicts strobes
// and read bits from the frame rules, and checks them as they appear.
module tb_spi_target_port;

  localparam int HALF = 8;

  logic        sys_clk = 1'b0;
  logic        reset, sclk, csb, sdio_in;
  logic        sdio_out, sdio_oe, reg_wr, reg_rd, frame_err;
  logic [12:0] reg_addr;
  logic [7:0]  reg_wdata, reg_rdata;

  int errors = 0;
  int checks = 0;
  int exp_ferr = 0;
  int seen_ferr = 0;

  logic [20:0] exp_wr_q[$];
  logic [12:0] exp_rd_q[$];
  logic [20:0] wr_log[$];
  logic [7:0]  rx_log[$];
  logic [7:0]  tx_q[$];

  always #10 sys_clk = ~sys_clk;

  spi_target_port #(.SYNC_STAGES(2), .ADDR_W(13)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .sclk      (sclk),
    .csb       (csb),
    .sdio_in   (sdio_in),
    .sdio_out  (sdio_out),
    .sdio_oe   (sdio_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .frame_err (frame_err)
  );

  function automatic logic [7:0] rd_val(input logic [12:0] a);
    return a[7:0] ^ 8'h34;
  endfunction

  // Register file responder: data is only valid exactly 2 cycles after reg_rd
  logic        rd_d1 = 1'b0, rd_d2 = 1'b0;
  logic [12:0] a1 = 13'd0, a2 = 13'd0;
  always @(posedge sys_clk) begin
    rd_d1 <= reg_rd;
    rd_d2 <= rd_d1;
    a1    <= reg_addr;
    a2    <= a1;
  end
  assign reg_rdata = rd_d2 ? rd_val(a2) : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe comparison against the expectation queues on every cycle
  always @(negedge sys_clk) begin
    logic [20:0] ew;
    logic [12:0] er;
    if (reg_wr && reg_rd) check("wr_rd_same_cycle", {reg_wr, reg_rd}, 2'b10);
    if (frame_err) seen_ferr++;
    if (reg_wr) begin
      wr_log.push_back({reg_addr, reg_wdata});
      if (exp_wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h expected no write", reg_addr, reg_wdata);
      end else begin
        ew = exp_wr_q.pop_front();
        check("wr_addr", reg_addr, ew[20:8]);
        check("wr_data", reg_wdata, ew[7:0]);
      end
    end
    if (reg_rd) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd: got addr 0x%0h expected no read", reg_addr);
      end else begin
        er = exp_rd_q.pop_front();
        check("rd_addr", reg_addr, er);
      end
    end
  end

  // One frame: predict strobes/err from the instruction, drive bits, check read bits.
  // rst_at >= 0 asserts reset after that many bits instead of a clean csb rise.
  task automatic run_frame(input logic [15:0] instr, input int nbits, input int rst_at);
    logic        rw, stream, bv, q, oe;
    logic [12:0] base;
    logic [7:0]  tmp, rx;
    int nb, mbits, full, done_b, nrd, k, bi, ferr;
    rw     = instr[15];
    stream = (instr[14:13] == 2'b11);
    nb     = stream ? 1000 : int'(instr[14:13]) + 1;
    base   = instr[12:0];
    mbits  = (rst_at >= 0) ? rst_at : nbits;
    full   = (mbits > 16) ? (mbits - 16) / 8 : 0;
    done_b = (full < nb) ? full : nb;
    nrd    = (full + 1 < nb) ? full + 1 : nb;
    wr_log.delete();
    rx_log.delete();
    rx = 8'd0;
    if (mbits >= 16) begin
      if (!rw) for (int i = 0; i < done_b; i++) exp_wr_q.push_back({base + 13'(i), tx_q[i]});
      else     for (int i = 0; i < nrd; i++)    exp_rd_q.push_back(base + 13'(i));
    end
    if (mbits < 16)                         ferr = 1;
    else if (!stream && full >= nb)         ferr = 0;
    else if (((mbits - 16) % 8) != 0)       ferr = 1;
    else                                    ferr = stream ? 0 : 1;
    if (rst_at < 0) exp_ferr += ferr;

    csb = 1'b0;
    repeat (2 * HALF) @(negedge sys_clk);
    for (int b = 0; b < mbits; b++) begin
      if (b < 16) bv = instr[15-b];
      else if (!rw && ((b - 16) / 8) < tx_q.size()) begin
        tmp = tx_q[(b - 16) / 8];
        bv  = tmp[7 - ((b - 16) % 8)];
      end else bv = 1'b1;
      sdio_in = bv;
      repeat (HALF) @(negedge sys_clk);
      q  = sdio_out;
      oe = sdio_oe;
      sclk = 1'b1;
      repeat (HALF) @(negedge sys_clk);
      sclk = 1'b0;
      if (b < 16) check("oe_during_instr", oe, 1'b0);
      else if (rw) begin
        k  = (b - 16) / 8;
        bi = 7 - ((b - 16) % 8);
        if (k < nb) begin
          tmp = rd_val(base + 13'(k));
          check("oe_during_data", oe, 1'b1);
          check("sdio_bit", q, tmp[bi]);
          rx = {rx[6:0], q};
          if (bi == 0) rx_log.push_back(rx);
        end else check("oe_after_count", oe, 1'b0);
      end
    end

    if (rst_at >= 0) begin
      reset = 1'b1;
      #1;
      check("oe_on_reset", sdio_oe, 1'b0);
      check("out_on_reset", sdio_out, 1'b0);
      repeat (3) @(negedge sys_clk);
      reset = 1'b0;
      for (int b = 0; b < 8; b++) begin
        repeat (HALF) @(negedge sys_clk);
        sclk = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        sclk = 1'b0;
      end
    end

    repeat (HALF) @(negedge sys_clk);
    if (rw && rst_at < 0 && !stream && full >= nb) check("oe_released_done", sdio_oe, 1'b0);
    csb = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("oe_after_csb", sdio_oe, 1'b0);
    repeat (2 * HALF) @(negedge sys_clk);
    check("frame_err_count", seen_ferr, exp_ferr);
    check("pending_writes", exp_wr_q.size(), 0);
    check("pending_reads", exp_rd_q.size(), 0);
  endtask

  initial begin
    int f0;
    reset = 1'b1; sclk = 1'b0; csb = 1'b1; sdio_in = 1'b0;
    repeat (4) @(negedge sys_clk);
    check("rst_oe", sdio_oe, 1'b0);
    check("rst_out", sdio_out, 1'b0);
    check("rst_wr", reg_wr, 1'b0);
    check("rst_rd", reg_rd, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_addr", reg_addr, 13'h0000);
    check("rst_wdata", reg_wdata, 8'h00);
    reset = 1'b0;
    repeat (6) @(negedge sys_clk);

    // single write
    tx_q = '{8'hA5};
    run_frame(16'h0014, 24, -1);
    check("w1_count", wr_log.size(), 1);
    if (wr_log.size() == 1) check("w1_entry", wr_log[0], {13'h014, 8'hA5});

    // single read, 0x008 -> 0x3C
    run_frame(16'h8008, 24, -1);
    check("r1_count", rx_log.size(), 1);
    if (rx_log.size() == 1) check("r1_byte", rx_log[0], 8'h3C);

    // streaming write across the address wrap
    tx_q = '{8'h11, 8'h22, 8'h33};
    run_frame(16'h7FFF, 40, -1);
    check("ws_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("ws_0", wr_log[0], {13'h1FFF, 8'h11});
      check("ws_1", wr_log[1], {13'h0000, 8'h22});
      check("ws_2", wr_log[2], {13'h0001, 8'h33});
    end

    // 2-byte write cut off mid second byte
    tx_q = '{8'hAA, 8'hBB};
    f0 = seen_ferr;
    run_frame(16'h2010, 28, -1);
    check("wt_count", wr_log.size(), 1);
    if (wr_log.size() == 1) check("wt_entry", wr_log[0], {13'h010, 8'hAA});
    check("wt_ferr_once", seen_ferr - f0, 1);

    // reset during second byte of a 3-byte read, then a full 3-byte read
    run_frame(16'hC020, 0, 28);
    run_frame(16'hC030, 40, -1);
    check("r3_count", rx_log.size(), 3);
    if (rx_log.size() == 3) begin
      check("r3_0", rx_log[0], 8'h04);
      check("r3_1", rx_log[1], 8'h05);
      check("r3_2", rx_log[2], 8'h06);
    end

    // write with trailing clocks in DONE
    tx_q = '{8'h77};
    f0 = seen_ferr;
    run_frame(16'h0005, 32, -1);
    check("wx_count", wr_log.size(), 1);
    check("wx_no_ferr", seen_ferr - f0, 0);

    // aborted instruction, mid-byte read abort, streaming read on a byte boundary
    run_frame(16'h0000, 7, -1);
    run_frame(16'h8100, 20, -1);
    f0 = seen_ferr;
    run_frame(16'hE100, 32, -1);
    check("rs_count", rx_log.size(), 2);
    check("rs_no_ferr", seen_ferr - f0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
